// File: rtl/execute_control_pkg.sv
// Shared definitions for the execute-stage sequencer: FSM state encoding,
// writeback result-select codes and the default load-timeout settings.
package execute_control_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_WB       = 2'd3
  } exu_state_e;

  // Writeback result-select encodings
  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_CMP  = 2'd1;
  localparam logic [1:0] RES_CSR  = 2'd2;
  localparam logic [1:0] RES_LOAD = 2'd3;

  // Default load-timeout configuration
  localparam int DEFAULT_MEM_TIMEOUT = 255;
  localparam int DEFAULT_TO_W        = 8;

  // Picks the non-load writeback value. RES_LOAD has no datapath source at
  // accept time, so it yields 0; a real load overwrites it with LSU data.
  function automatic logic [31:0] select_result(
    input logic [1:0]  sel,
    input logic [31:0] alu_out,
    input logic [31:0] compare_out,
    input logic [31:0] csr_rdata
  );
    logic [31:0] res;
    res = 32'd0;
    case (sel)
      RES_ALU: res = alu_out;
      RES_CMP: res = compare_out;
      RES_CSR: res = csr_rdata;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exu_timeout_counter.sv
// Load-response watchdog. Counts cycles while enabled and flags expiry on the
// cycle whose increment would reach LIMIT, so the caller can abort in that
// same cycle.
module exu_timeout_counter #(
  parameter int TO_W  = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i & ~clear_i & (cnt_q == LAST);

endmodule

// File: rtl/execute_control.sv
// Execute-stage sequencer: accepts decoded instructions from the IDU, issues
// a single LSU read for loads, and hands the final result to the WBU. CSR
// writes commit only on the writeback handshake.
module execute_control
  import execute_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int TO_W        = DEFAULT_TO_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exu_in_valid_i,
  output logic        exu_in_ready_o,
  input  logic        exu_re_i,
  input  logic        exu_wen_i,
  input  logic        exu_csr_wen_i,
  input  logic [4:0]  exu_rd_i,
  input  logic [1:0]  exu_result_sel_i,
  input  logic [31:0] exu_alu_out_i,
  input  logic [31:0] exu_compare_out_i,
  input  logic [31:0] exu_csr_rdata_i,
  input  logic [31:0] exu_csr_wdata_i,
  input  logic [31:0] exu_csr_waddr_i,
  output logic        lsu_req_valid_o,
  input  logic        lsu_req_ready_i,
  output logic [31:0] lsu_addr_o,
  input  logic        lsu_resp_valid_i,
  input  logic [31:0] lsu_rdata_i,
  output logic        wbu_valid_o,
  input  logic        wbu_ready_i,
  output logic        wbu_wen_o,
  output logic [4:0]  wbu_rd_o,
  output logic [31:0] wbu_wdata_o,
  output logic        csr_wen_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        exu_err_o,
  output logic [31:0] exu_retire_cnt_o
);

  exu_state_e  state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        wen_q, wen_d;
  logic        csr_wen_q, csr_wen_d;
  logic [31:0] csr_waddr_q, csr_waddr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic        accept;
  logic        wb_fire;
  logic        to_clear;
  logic        to_enable;
  logic        to_expire;

  // Handshake qualifiers; ready depends combinationally on wbu_ready_i so a
  // new instruction can enter in the same cycle the previous one retires
  assign wb_fire        = (state_q == ST_WB) & wbu_ready_i;
  assign exu_in_ready_o = (state_q == ST_IDLE) | wb_fire;
  assign accept         = exu_in_valid_i & exu_in_ready_o;

  // Watchdog runs only while waiting for a response; the response wins a tie
  assign to_clear  = (state_q == ST_MEM_REQ) & lsu_req_ready_i;
  assign to_enable = (state_q == ST_MEM_WAIT) & ~lsu_resp_valid_i;

  exu_timeout_counter #(
    .TO_W  (TO_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (to_clear),
    .enable_i (to_enable),
    .expire_o (to_expire)
  );

  // Next-state and latch update; a fresh accept overrides the retiring path
  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wen_d        = wen_q;
    csr_wen_d    = csr_wen_q;
    csr_waddr_d  = csr_waddr_q;
    csr_wdata_d  = csr_wdata_q;
    addr_d       = addr_q;
    result_d     = result_q;
    err_d        = err_q;
    retire_cnt_d = retire_cnt_q;

    case (state_q)
      ST_MEM_REQ: begin
        if (lsu_req_ready_i) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (lsu_resp_valid_i) begin
          result_d = lsu_rdata_i;
          state_d  = ST_WB;
        end else if (to_expire) begin
          err_d     = 1'b1;
          wen_d     = 1'b0;
          csr_wen_d = 1'b0;
          result_d  = 32'd0;
          state_d   = ST_WB;
        end
      end
      ST_WB: begin
        if (wbu_ready_i) begin
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (accept) begin
      rd_d        = exu_rd_i;
      wen_d       = exu_wen_i;
      csr_wen_d   = exu_csr_wen_i;
      csr_waddr_d = exu_csr_waddr_i;
      csr_wdata_d = exu_csr_wdata_i;
      addr_d      = exu_alu_out_i;
      result_d    = select_result(exu_result_sel_i, exu_alu_out_i,
                                  exu_compare_out_i, exu_csr_rdata_i);
      state_d     = exu_re_i ? ST_MEM_REQ : ST_WB;
    end
  end

  // State and latch registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_q         <= '0;
      wen_q        <= 1'b0;
      csr_wen_q    <= 1'b0;
      csr_waddr_q  <= '0;
      csr_wdata_q  <= '0;
      addr_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wen_q        <= wen_d;
      csr_wen_q    <= csr_wen_d;
      csr_waddr_q  <= csr_waddr_d;
      csr_wdata_q  <= csr_wdata_d;
      addr_q       <= addr_d;
      result_q     <= result_d;
      err_q        <= err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign lsu_req_valid_o  = (state_q == ST_MEM_REQ);
  assign lsu_addr_o       = addr_q;
  assign wbu_valid_o      = (state_q == ST_WB);
  assign wbu_wen_o        = wen_q;
  assign wbu_rd_o         = rd_q;
  assign wbu_wdata_o      = result_q;
  assign csr_wen_o        = wb_fire & csr_wen_q;
  assign csr_waddr_o      = csr_waddr_q;
  assign csr_wdata_o      = csr_wdata_q;
  assign exu_err_o        = err_q;
  assign exu_retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_execute_control.sv
// Directed bench for execute_control, built with a short load timeout so the
// abort and response-on-expiry cases are reachable in a few cycles.
module tb_execute_control;
  import execute_control_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        exu_in_valid;
  logic        exu_in_ready;
  logic        exu_re;
  logic        exu_wen;
  logic        exu_csr_wen;
  logic [4:0]  exu_rd;
  logic [1:0]  exu_result_sel;
  logic [31:0] exu_alu_out;
  logic [31:0] exu_compare_out;
  logic [31:0] exu_csr_rdata;
  logic [31:0] exu_csr_wdata;
  logic [31:0] exu_csr_waddr;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        wbu_valid;
  logic        wbu_ready;
  logic        wbu_wen;
  logic [4:0]  wbu_rd;
  logic [31:0] wbu_wdata;
  logic        csr_wen;
  logic [31:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        exu_err;
  logic [31:0] exu_retire_cnt;

  int check_count = 0;
  int error_count = 0;

  execute_control #(
    .MEM_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .exu_in_valid_i    (exu_in_valid),
    .exu_in_ready_o    (exu_in_ready),
    .exu_re_i          (exu_re),
    .exu_wen_i         (exu_wen),
    .exu_csr_wen_i     (exu_csr_wen),
    .exu_rd_i          (exu_rd),
    .exu_result_sel_i  (exu_result_sel),
    .exu_alu_out_i     (exu_alu_out),
    .exu_compare_out_i (exu_compare_out),
    .exu_csr_rdata_i   (exu_csr_rdata),
    .exu_csr_wdata_i   (exu_csr_wdata),
    .exu_csr_waddr_i   (exu_csr_waddr),
    .lsu_req_valid_o   (lsu_req_valid),
    .lsu_req_ready_i   (lsu_req_ready),
    .lsu_addr_o        (lsu_addr),
    .lsu_resp_valid_i  (lsu_resp_valid),
    .lsu_rdata_i       (lsu_rdata),
    .wbu_valid_o       (wbu_valid),
    .wbu_ready_i       (wbu_ready),
    .wbu_wen_o         (wbu_wen),
    .wbu_rd_o          (wbu_rd),
    .wbu_wdata_o       (wbu_wdata),
    .csr_wen_o         (csr_wen),
    .csr_waddr_o       (csr_waddr),
    .csr_wdata_o       (csr_wdata),
    .exu_err_o         (exu_err),
    .exu_retire_cnt_o  (exu_retire_cnt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one decoded instruction onto the IDU-side inputs
  task automatic applyStimulus(input logic valid, input logic re, input logic wen,
                               input logic cwen, input logic [4:0] rd,
                               input logic [1:0] sel, input logic [31:0] alu,
                               input logic [31:0] cmp, input logic [31:0] crd,
                               input logic [31:0] cwd, input logic [31:0] cwa);
    exu_in_valid    = valid;
    exu_re          = re;
    exu_wen         = wen;
    exu_csr_wen     = cwen;
    exu_rd          = rd;
    exu_result_sel  = sel;
    exu_alu_out     = alu;
    exu_compare_out = cmp;
    exu_csr_rdata   = crd;
    exu_csr_wdata   = cwd;
    exu_csr_waddr   = cwa;
  endtask

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_exp [4];

  initial begin
    rst_n          = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = 32'd0;
    wbu_ready      = 1'b0;
    applyStimulus(0, 0, 0, 0, 5'd0, RES_ALU, 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    #2;
    checkOutput("reset_in_ready", {31'd0, exu_in_ready}, 32'd1);
    checkOutput("reset_wbu_valid", {31'd0, wbu_valid}, 32'd0);
    checkOutput("reset_lsu_valid", {31'd0, lsu_req_valid}, 32'd0);
    checkOutput("reset_err", {31'd0, exu_err}, 32'd0);
    checkOutput("reset_retire", exu_retire_cnt, 32'd0);

    // addi-like instruction, one-cycle latency to writeback
    $display("[TB] addi-like writeback");
    wbu_ready = 1'b1;
    applyStimulus(1, 0, 1, 0, 5'd5, RES_ALU, 32'h10, 32'hFF, 32'hEE, 0, 0);
    stepCycle();
    exu_in_valid = 1'b0;
    #2;
    checkOutput("addi_wbu_valid", {31'd0, wbu_valid}, 32'd1);
    checkOutput("addi_wdata", wbu_wdata, 32'h10);
    checkOutput("addi_rd", {27'd0, wbu_rd}, 32'd5);
    checkOutput("addi_wen", {31'd0, wbu_wen}, 32'd1);
    stepCycle();
    #2;
    checkOutput("addi_idle", {31'd0, wbu_valid}, 32'd0);
    checkOutput("addi_retire", exu_retire_cnt, 32'd1);

    // Load: LSU stalls two cycles, response on the third wait cycle
    $display("[TB] load with LSU stalls");
    applyStimulus(1, 1, 1, 0, 5'd7, RES_LOAD, 32'h8000_0004, 0, 0, 0, 0);
    stepCycle();
    exu_in_valid   = 1'b0;
    exu_alu_out    = 32'h1234_5678;
    lsu_resp_valid = 1'b1;
    lsu_rdata      = 32'h0BAD_0BAD;
    #2;
    checkOutput("ld_req_valid0", {31'd0, lsu_req_valid}, 32'd1);
    checkOutput("ld_addr0", lsu_addr, 32'h8000_0004);
    stepCycle();
    lsu_resp_valid = 1'b0;
    #2;
    checkOutput("ld_req_valid1", {31'd0, lsu_req_valid}, 32'd1);
    checkOutput("ld_addr1", lsu_addr, 32'h8000_0004);
    checkOutput("ld_no_wb1", {31'd0, wbu_valid}, 32'd0);
    stepCycle();
    lsu_req_ready = 1'b1;
    #2;
    checkOutput("ld_req_valid2", {31'd0, lsu_req_valid}, 32'd1);
    checkOutput("ld_addr2", lsu_addr, 32'h8000_0004);
    stepCycle();
    lsu_req_ready = 1'b0;
    #2;
    checkOutput("ld_wait_req_low", {31'd0, lsu_req_valid}, 32'd0);
    checkOutput("ld_wait_no_wb", {31'd0, wbu_valid}, 32'd0);
    stepCycle();
    stepCycle();
    lsu_resp_valid = 1'b1;
    lsu_rdata      = 32'hDEAD_BEEF;
    stepCycle();
    lsu_resp_valid = 1'b0;
    #2;
    checkOutput("ld_wbu_valid", {31'd0, wbu_valid}, 32'd1);
    checkOutput("ld_wdata", wbu_wdata, 32'hDEAD_BEEF);
    checkOutput("ld_rd", {27'd0, wbu_rd}, 32'd7);
    checkOutput("ld_wen", {31'd0, wbu_wen}, 32'd1);
    stepCycle();
    #2;
    checkOutput("ld_retire", exu_retire_cnt, 32'd2);

    // Four back-to-back non-loads, one per cycle, each result source in turn
    $display("[TB] back-to-back non-loads");
    b2b_exp[0] = 32'h0000_0100;
    b2b_exp[1] = 32'h0000_0001;
    b2b_exp[2] = 32'h0000_C5C5;
    b2b_exp[3] = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) applyStimulus(1, 0, 1, 0, 5'd10, RES_ALU, 32'h100, 32'hF0F0, 32'h77, 0, 0);
      if (i == 1) applyStimulus(1, 0, 1, 0, 5'd11, RES_CMP, 32'h200, 32'h1, 32'h88, 0, 0);
      if (i == 2) applyStimulus(1, 0, 1, 0, 5'd12, RES_CSR, 32'h300, 32'h2, 32'hC5C5, 0, 0);
      if (i == 3) applyStimulus(1, 0, 1, 0, 5'd13, RES_LOAD, 32'h400, 32'h3, 32'h99, 0, 0);
      if (i == 4) exu_in_valid = 1'b0;
      #2;
      if (i > 0) begin
        checkOutput($sformatf("b2b_valid%0d", i - 1), {31'd0, wbu_valid}, 32'd1);
        checkOutput($sformatf("b2b_wdata%0d", i - 1), wbu_wdata, b2b_exp[i - 1]);
        checkOutput($sformatf("b2b_rd%0d", i - 1), {27'd0, wbu_rd}, 32'(9 + i));
      end
      checkOutput($sformatf("b2b_ready%0d", i), {31'd0, exu_in_ready}, 32'd1);
      stepCycle();
    end
    #2;
    checkOutput("b2b_retire", exu_retire_cnt, 32'd6);

    // csrrw held in writeback by a stalled WBU; commit only on handshake
    $display("[TB] csrrw with WBU backpressure");
    wbu_ready = 1'b0;
    applyStimulus(1, 0, 1, 1, 5'd3, RES_CSR, 32'h5, 32'h6, 32'hAAAA, 32'h1234, 32'h300);
    stepCycle();
    exu_in_valid  = 1'b0;
    exu_csr_wdata = 32'hFFFF_0000;
    exu_csr_waddr = 32'h0000_0FFF;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput($sformatf("csr_stall_valid%0d", i), {31'd0, wbu_valid}, 32'd1);
      checkOutput($sformatf("csr_stall_wen%0d", i), {31'd0, csr_wen}, 32'd0);
      checkOutput($sformatf("csr_stall_wdata%0d", i), wbu_wdata, 32'hAAAA);
      checkOutput($sformatf("csr_stall_rd%0d", i), {27'd0, wbu_rd}, 32'd3);
      checkOutput($sformatf("csr_stall_ready%0d", i), {31'd0, exu_in_ready}, 32'd0);
      stepCycle();
    end
    wbu_ready = 1'b1;
    #2;
    checkOutput("csr_commit_wen", {31'd0, csr_wen}, 32'd1);
    checkOutput("csr_commit_addr", csr_waddr, 32'h300);
    checkOutput("csr_commit_data", csr_wdata, 32'h1234);
    stepCycle();
    #2;
    checkOutput("csr_after_wen", {31'd0, csr_wen}, 32'd0);
    checkOutput("csr_after_valid", {31'd0, wbu_valid}, 32'd0);
    checkOutput("csr_retire", exu_retire_cnt, 32'd7);

    // Response on the very cycle the watchdog would expire: data wins
    $display("[TB] response on expiry cycle");
    applyStimulus(1, 1, 1, 0, 5'd9, RES_LOAD, 32'h8000_0010, 0, 0, 0, 0);
    stepCycle();
    exu_in_valid  = 1'b0;
    lsu_req_ready = 1'b1;
    stepCycle();
    lsu_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput($sformatf("race_wait%0d", i), {31'd0, wbu_valid}, 32'd0);
      stepCycle();
    end
    lsu_resp_valid = 1'b1;
    lsu_rdata      = 32'hCAFE_F00D;
    stepCycle();
    lsu_resp_valid = 1'b0;
    #2;
    checkOutput("race_wbu_valid", {31'd0, wbu_valid}, 32'd1);
    checkOutput("race_wdata", wbu_wdata, 32'hCAFE_F00D);
    checkOutput("race_wen", {31'd0, wbu_wen}, 32'd1);
    checkOutput("race_err", {31'd0, exu_err}, 32'd0);
    stepCycle();
    #2;
    checkOutput("race_retire", exu_retire_cnt, 32'd8);

    // No response at all: abort after four wait cycles, sticky error
    $display("[TB] load timeout");
    applyStimulus(1, 1, 1, 1, 5'd11, RES_LOAD, 32'h8000_0020, 0, 0, 32'h55, 32'h305);
    stepCycle();
    exu_in_valid  = 1'b0;
    lsu_req_ready = 1'b1;
    stepCycle();
    lsu_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checkOutput($sformatf("to_wait_err%0d", i), {31'd0, exu_err}, 32'd0);
      checkOutput($sformatf("to_wait_valid%0d", i), {31'd0, wbu_valid}, 32'd0);
      stepCycle();
    end
    #2;
    checkOutput("to_err", {31'd0, exu_err}, 32'd1);
    checkOutput("to_wbu_valid", {31'd0, wbu_valid}, 32'd1);
    checkOutput("to_wen", {31'd0, wbu_wen}, 32'd0);
    checkOutput("to_wdata", wbu_wdata, 32'd0);
    checkOutput("to_csr_wen", {31'd0, csr_wen}, 32'd0);
    stepCycle();
    #2;
    checkOutput("to_err_sticky", {31'd0, exu_err}, 32'd1);
    checkOutput("to_retire", exu_retire_cnt, 32'd9);

    // Reset while waiting on a load; a late response must be ignored
    $display("[TB] reset during MEM_WAIT");
    applyStimulus(1, 1, 1, 0, 5'd4, RES_LOAD, 32'h8000_0030, 0, 0, 0, 0);
    stepCycle();
    exu_in_valid  = 1'b0;
    lsu_req_ready = 1'b1;
    stepCycle();
    lsu_req_ready = 1'b0;
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    #2;
    checkOutput("rst_in_ready", {31'd0, exu_in_ready}, 32'd1);
    checkOutput("rst_wbu_valid", {31'd0, wbu_valid}, 32'd0);
    checkOutput("rst_lsu_valid", {31'd0, lsu_req_valid}, 32'd0);
    checkOutput("rst_retire", exu_retire_cnt, 32'd0);
    checkOutput("rst_err", {31'd0, exu_err}, 32'd0);
    lsu_resp_valid = 1'b1;
    lsu_rdata      = 32'h7777_7777;
    stepCycle();
    lsu_resp_valid = 1'b0;
    #2;
    checkOutput("late_resp_valid", {31'd0, wbu_valid}, 32'd0);
    checkOutput("late_resp_ready", {31'd0, exu_in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/execute_control.md
Name: execute_control

Overview:
Multi-cycle sequencer wrapped around the combinational decode/execute datapath.
- Accepts one decoded instruction per handshake from the IDU and latches the datapath results.
- For loads, issues a single read to the LSU and waits for the response.
- Presents the final writeback to the WBU with valid/ready, and commits CSR writes only when the writeback handshake completes.

Parameters:
MEM_TIMEOUT, 255, cycles allowed in MEM_WAIT before abort (1..2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
exu_in_valid_i  in  1  IDU has an instruction
exu_in_ready_o  out  1  block can accept
exu_re_i  in  1  load (mem read enable from datapath)
exu_wen_i  in  1  GPR write enable from datapath
exu_csr_wen_i  in  1  CSR write enable from datapath
exu_rd_i  in  5  destination register
exu_result_sel_i  in  2  0=alu_out, 1=compare_out, 2=csr_rdata, 3=load data
exu_alu_out_i  in  32  ALU result (load address when exu_re_i)
exu_compare_out_i  in  32  compare result
exu_csr_rdata_i  in  32  CSR read data
exu_csr_wdata_i  in  32  CSR write data
exu_csr_waddr_i  in  32  CSR write address
lsu_req_valid_o  out  1  load request
lsu_req_ready_i  in  1  LSU accepts request
lsu_addr_o  out  32  load address
lsu_resp_valid_i  in  1  load data valid
lsu_rdata_i  in  32  load data
wbu_valid_o  out  1  writeback valid
wbu_ready_i  in  1  WBU accepts
wbu_wen_o  out  1  GPR write enable
wbu_rd_o  out  5  destination register
wbu_wdata_o  out  32  writeback data
csr_wen_o  out  1  one-cycle CSR commit strobe
csr_waddr_o  out  32  CSR address
csr_wdata_o  out  32  CSR data
exu_err_o  out  1  sticky load-timeout flag
exu_retire_cnt_o  out  32  retired-instruction counter

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; every registered output and internal latch goes to 0; exu_err_o=0; retire count=0.
  - An in-flight load is abandoned; the LSU is reset by the same rst_n.
- States: IDLE, MEM_REQ, MEM_WAIT, WB.
- Accept condition:
  - exu_in_ready_o = (state==IDLE) | (state==WB & wbu_ready_i). This is combinational from wbu_ready_i.
  - On exu_in_valid_i & exu_in_ready_o, latch all exu_* inputs, then go to MEM_REQ if exu_re_i, else to WB.
  - For non-loads, the latched result is selected by exu_result_sel_i at accept. Sel=3 with re=0 is illegal and yields 0.
- MEM_REQ:
  - lsu_req_valid_o=1, lsu_addr_o = latched alu_out, held stable until lsu_req_ready_i.
  - On handshake, go to MEM_WAIT and clear the timeout counter.
  - lsu_resp_valid_i is ignored in this state; the response comes no earlier than the cycle after acceptance.
- MEM_WAIT:
  - On lsu_resp_valid_i, latch lsu_rdata_i as the result and go to WB.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT, set exu_err_o (sticky), force the latched wen and csr_wen to 0, set the result to 0, and go to WB.
  - If the response and the timeout occur in the same cycle, the response wins.
- WB:
  - wbu_valid_o=1; wbu_wen_o, wbu_rd_o and wbu_wdata_o come from the latches and are held stable until wbu_ready_i.
  - On handshake: pulse csr_wen_o for exactly that cycle (if the latched csr_wen is set), increment exu_retire_cnt_o (wraps 0xFFFFFFFF->0), then go to IDLE.
  - If a new instruction is accepted in the same cycle, go directly to that instruction's next state instead.
- Throughput and latency:
  - Back-to-back non-loads with wbu_ready_i held high achieve 1 instruction/cycle after the first.
  - Latency from accept to wbu_valid_o: 1 cycle for non-loads; 2 + (LSU ready wait) + (response wait) for loads.
- Outputs:
  - wbu_valid_o and lsu_req_valid_o never drop without a handshake, except on reset.
  - csr_waddr_o and csr_wdata_o are valid whenever csr_wen_o is high.

Decomposition:
- Shared header (alongside the existing riscv_param.vh): state encodings, result_sel encodings (RES_ALU, RES_CMP, RES_CSR, RES_LOAD), and the default MEM_TIMEOUT.
- Natural sub-module: exu_timeout_counter (clear/enable/expire, TO_W wide).
- The FSM and latches stay in execute_control.

Test Plan:
- addi-like: valid with re=0, wen=1, sel=0, alu_out=0x10, wbu_ready=1 -> wbu_valid_o one cycle later with wdata=0x10, rd as given; retire count becomes 1.
- Load: re=1, alu_out=0x80000004; LSU ready after 2 cycles, response 0xDEADBEEF 3 cycles later -> lsu_addr_o stable 0x80000004 throughout MEM_REQ; wbu_wdata_o=0xDEADBEEF.
- Back-to-back: 4 non-loads with valid and wbu_ready continuously high -> 4 writebacks on consecutive cycles; retire count=4.
- csrrw with wbu_ready held low for 3 cycles -> csr_wen_o stays 0 until the handshake cycle, then is high for exactly 1 cycle; WB outputs stable throughout.
- Timeout with MEM_TIMEOUT=4 and no response -> exu_err_o rises and stays high; writeback with wen=0, wdata=0; a response arriving on the expiry cycle instead returns its data with no error.
- Reset asserted in MEM_WAIT -> next cycle: state IDLE, all valids 0, exu_in_ready_o=1, retire count 0; a late lsu_resp_valid_i is ignored.
